accum_arbiter: RTL and testbench
================================

ACCUM_ARBITER -- requirements
Module: accum_arbiter

Interface
REQ-001 Parameter: WIDTH, default 16, data/accumulator width in bits.
REQ-002 Parameter: LEN_W, default 4, burst-length field width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-005 req  input  2  per-requester request; bit i = requester i wants the accumulator.
REQ-006 len0  input  LEN_W  requester 0 burst length (operand count), sampled at grant.
REQ-007 len1  input  LEN_W  requester 1 burst length, sampled at grant.
REQ-008 gnt  output  2  one-hot grant; at most one bit set.
REQ-009 in_data  input  WIDTH  operand from the granted requester.
REQ-010 in_valid  input  1  in_data valid this cycle.
REQ-011 in_ready  output  1  accumulator accepts an operand this cycle.
REQ-012 sum_out  output  WIDTH  accumulated result; meaningful when done=1.
REQ-013 ovf  output  1  sticky carry-out of the current burst; meaningful when done=1.
REQ-014 done  output  1  one-cycle pulse, result valid.
REQ-015 done_id  output  1  index of the requester whose result is on sum_out.

Function
REQ-016 FSM states SHALL be IDLE, ACCUM, DONE; reset state IDLE.
REQ-017 IDLE: if req!=0, next edge -> ACCUM, set gnt, latch granted len into counter, clear acc and ovf; else stay IDLE.
REQ-018 Arbitration SHALL be round-robin: single request wins; both requesting -> requester other than last served wins; last-served pointer resets to 1 (requester 0 wins first contention).
REQ-019 last-served pointer SHALL update only at grant.
REQ-020 ACCUM: in_ready=1; on edge with in_valid=1, acc <= (acc + in_data) mod 2^WIDTH, ovf <= ovf | carry-out, counter decrements.
REQ-021 in_valid=0 in ACCUM SHALL stall with no state change (no timeout).
REQ-022 Acceptance of the operand that brings counter to 0 SHALL move FSM to DONE on that edge.
REQ-023 Latched len=0 SHALL go from ACCUM to DONE on the first edge in ACCUM without accepting an operand (in_ready=0 that cycle), sum_out=0, ovf=0.
REQ-024 DONE: exactly one cycle, done=1, sum_out=acc, done_id=granted index, in_ready=0; next edge -> IDLE, gnt cleared.
REQ-025 gnt SHALL remain asserted and unchanged from ACCUM entry through the DONE cycle; req deassertion mid-burst SHALL NOT abort the burst.
REQ-026 A request arriving during ACCUM/DONE SHALL be serviced only after return to IDLE; minimum gap between bursts = 1 IDLE cycle.
REQ-027 in_ready SHALL be 0 in IDLE and DONE; operands presented there are ignored.
REQ-028 done, gnt, in_ready SHALL be registered or decoded from registered state only (no combinational path from req/in_valid).

Reset
REQ-029 reset=1 SHALL force state IDLE, gnt=0, in_ready=0, done=0, done_id=0, sum_out=0, ovf=0, counter=0, pointer=1, asynchronously.
REQ-030 reset asserted mid-burst SHALL discard the partial sum; no done pulse for that burst.
REQ-031 After reset release, first grant SHALL occur on the first rising edge with req!=0.

Verification
REQ-032 req=01, len0=2, operands 18 then 9 -> gnt=01, done pulse with sum_out=27, ovf=0, done_id=0.
REQ-033 req=11 from reset, len0=1 (data 5), len1=1 (data 7) held -> req0 served first (sum 5, id 0), then req1 (sum 7, id 1), one IDLE cycle between.
REQ-034 len0=2, operands 16'hFFFF and 16'h0002 -> sum_out=16'h0001, ovf=1.
REQ-035 len1=0, req=10 -> gnt=10 one ACCUM cycle, in_ready=0 throughout, done with sum_out=0, done_id=1.
REQ-036 len0=3, in_valid low 4 cycles between beats 4,4,4 -> no progress while low, done with sum_out=12.
REQ-037 reset pulsed after first of three beats (value 18) -> all outputs 0 immediately, no done; next burst len0=1 data 9 -> sum_out=9.

Source files
------------

// File: rtl/accum_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : accum_arbiter
// Description : Two-requester round-robin arbiter in front of a burst
//               accumulator with a sticky carry-out flag.
// Revision    : 1.0 - initial release
// ============================================================================
module accum_arbiter #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [1:0]       i_req,
  input  logic [LEN_W-1:0] i_len0,
  input  logic [LEN_W-1:0] i_len1,
  output logic [1:0]       o_gnt,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_sum_out,
  output logic             o_ovf,
  output logic             o_done,
  output logic             o_done_id
);

  localparam logic [LEN_W-1:0] c_CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_gnt;
  logic [LEN_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic             r_ovf;
  logic             r_ptr;
  logic             r_id;
  logic             w_win;
  logic             w_accept;
  logic [WIDTH:0]   w_add;

  // Contention goes to the requester that was not served last.
  assign w_win    = (i_req[0] & i_req[1]) ? ~r_ptr : i_req[1];
  assign w_accept = (r_state == ACCUM) && (r_cnt != '0) && i_in_valid;
  assign w_add    = {1'b0, r_acc} + {1'b0, i_in_data};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (|i_req) begin
          w_next = ACCUM;
        end
      end
      ACCUM: begin
        // A zero-length burst completes without taking any operand.
        if (r_cnt == '0) begin
          w_next = DONE;
        end else if (i_in_valid && (r_cnt == c_CNT_ONE)) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_gnt <= 2'b00;
      r_cnt <= '0;
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_ptr <= 1'b1;
      r_id  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|i_req) begin
            r_gnt <= w_win ? 2'b10 : 2'b01;
            r_id  <= w_win;
            r_ptr <= w_win;
            r_cnt <= w_win ? i_len1 : i_len0;
            r_acc <= '0;
            r_ovf <= 1'b0;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_acc <= w_add[WIDTH-1:0];
            r_ovf <= r_ovf | w_add[WIDTH];
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        DONE: begin
          r_gnt <= 2'b00;
        end
        default: begin
          r_gnt <= 2'b00;
        end
      endcase
    end
  end

  assign o_gnt      = r_gnt;
  assign o_in_ready = (r_state == ACCUM) && (r_cnt != '0);
  assign o_done     = (r_state == DONE);
  assign o_done_id  = r_id;
  assign o_sum_out  = r_acc;
  assign o_ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_accum_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_accum_arbiter
// Description : Directed self-checking bench for accum_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accum_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [3:0]  len0;
  logic [3:0]  len1;
  logic [1:0]  gnt;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sum_out;
  logic        ovf;
  logic        done;
  logic        done_id;

  int errors = 0;
  int checks = 0;

  accum_arbiter #(.WIDTH(16), .LEN_W(4)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_req      (req),
    .i_len0     (len0),
    .i_len1     (len1),
    .o_gnt      (gnt),
    .i_in_data  (in_data),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .o_sum_out  (sum_out),
    .o_ovf      (ovf),
    .o_done     (done),
    .o_done_id  (done_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".gnt"},   {30'd0, gnt}, 32'd0);
    chk({tag, ".rdy"},   {31'd0, in_ready}, 32'd0);
    chk({tag, ".done"},  {31'd0, done}, 32'd0);
    chk({tag, ".id"},    {31'd0, done_id}, 32'd0);
    chk({tag, ".sum"},   {16'd0, sum_out}, 32'd0);
    chk({tag, ".ovf"},   {31'd0, ovf}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; req = 2'b00; len0 = 4'd0; len1 = 4'd0;
    in_data = 16'd0; in_valid = 1'b0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Single requester, two beats 18 + 9
    req = 2'b01; len0 = 4'd2; in_valid = 1'b1; in_data = 16'd18;
    tick();
    chk("b1.gnt", {30'd0, gnt}, 32'h1);
    chk("b1.rdy", {31'd0, in_ready}, 32'h1);
    chk("b1.done0", {31'd0, done}, 32'h0);
    req = 2'b00;
    tick();
    in_data = 16'd9;
    tick();
    chk("b1.done", {31'd0, done}, 32'h1);
    chk("b1.sum", {16'd0, sum_out}, 32'd27);
    chk("b1.ovf", {31'd0, ovf}, 32'h0);
    chk("b1.id", {31'd0, done_id}, 32'h0);
    chk("b1.rdy_done", {31'd0, in_ready}, 32'h0);
    chk("b1.gnt_done", {30'd0, gnt}, 32'h1);
    in_valid = 1'b0;
    tick();
    chk("b1.idle_done", {31'd0, done}, 32'h0);
    chk("b1.idle_gnt", {30'd0, gnt}, 32'h0);

    // Fresh reset, then contention: requester 0 first, then 1
    reset = 1'b1;
    #1;
    reset = 1'b0;
    req = 2'b11; len0 = 4'd1; len1 = 4'd1; in_valid = 1'b1; in_data = 16'd5;
    tick();
    chk("rr.gnt0", {30'd0, gnt}, 32'h1);
    tick();
    chk("rr.done0", {31'd0, done}, 32'h1);
    chk("rr.sum0", {16'd0, sum_out}, 32'd5);
    chk("rr.id0", {31'd0, done_id}, 32'h0);
    in_data = 16'd7;
    tick();
    chk("rr.gap_gnt", {30'd0, gnt}, 32'h0);
    chk("rr.gap_done", {31'd0, done}, 32'h0);
    tick();
    chk("rr.gnt1", {30'd0, gnt}, 32'h2);
    tick();
    chk("rr.done1", {31'd0, done}, 32'h1);
    chk("rr.sum1", {16'd0, sum_out}, 32'd7);
    chk("rr.id1", {31'd0, done_id}, 32'h1);
    req = 2'b00; in_valid = 1'b0;
    tick();

    // Carry-out: FFFF + 0002
    req = 2'b01; len0 = 4'd2; in_valid = 1'b1; in_data = 16'hFFFF;
    tick();
    req = 2'b00;
    tick();
    in_data = 16'h0002;
    tick();
    chk("ovf.done", {31'd0, done}, 32'h1);
    chk("ovf.sum", {16'd0, sum_out}, 32'h0001);
    chk("ovf.flag", {31'd0, ovf}, 32'h1);
    in_valid = 1'b0;
    tick();

    // Zero-length burst on requester 1
    req = 2'b10; len1 = 4'd0; in_valid = 1'b1; in_data = 16'h0055;
    tick();
    chk("z.gnt", {30'd0, gnt}, 32'h2);
    chk("z.rdy", {31'd0, in_ready}, 32'h0);
    req = 2'b00;
    tick();
    chk("z.done", {31'd0, done}, 32'h1);
    chk("z.sum", {16'd0, sum_out}, 32'h0);
    chk("z.ovf", {31'd0, ovf}, 32'h0);
    chk("z.id", {31'd0, done_id}, 32'h1);
    chk("z.rdy_done", {31'd0, in_ready}, 32'h0);
    in_valid = 1'b0;
    tick();

    // Stalls of 4 cycles before each of three beats of 4
    req = 2'b01; len0 = 4'd3; in_valid = 1'b0; in_data = 16'd4;
    tick();
    req = 2'b00;
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b0;
      repeat (4) begin
        tick();
        chk("st.sum_hold", {16'd0, sum_out}, 32'(4 * b));
        chk("st.rdy", {31'd0, in_ready}, 32'h1);
        chk("st.nodone", {31'd0, done}, 32'h0);
      end
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
    end
    chk("st.done", {31'd0, done}, 32'h1);
    chk("st.sum", {16'd0, sum_out}, 32'd12);
    chk("st.id", {31'd0, done_id}, 32'h0);
    tick();

    // Reset in the middle of a burst
    req = 2'b01; len0 = 4'd3; in_valid = 1'b1; in_data = 16'd18;
    tick();
    req = 2'b00;
    tick();
    chk("mr.partial", {16'd0, sum_out}, 32'd18);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("mr.async");
    reset = 1'b0; in_valid = 1'b0;
    repeat (2) begin
      tick();
      chk("mr.nodone", {31'd0, done}, 32'h0);
      chk("mr.nognt", {30'd0, gnt}, 32'h0);
    end
    req = 2'b01; len0 = 4'd1; in_valid = 1'b1; in_data = 16'd9;
    tick();
    chk("mr.gnt", {30'd0, gnt}, 32'h1);
    req = 2'b00;
    tick();
    chk("mr.done", {31'd0, done}, 32'h1);
    chk("mr.sum", {16'd0, sum_out}, 32'd9);
    chk("mr.id", {31'd0, done_id}, 32'h0);
    in_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
